icache_refill_responder: RTL and testbench
==========================================

Name: icache_refill_responder

Overview:
- Memory-side responder for instruction-cache line refills.
- Accepts one line-fill request at a time and reads ICLLEN/32 words from an internal word-addressed backing store.
- Latency is fixed: MEM_LATENCY wait cycles, then one word per cycle.
- Returns the assembled line over a valid/ready response channel. Includes a word write port used to preload program images.

Parameters:
XLEN, 32, address width
ICLLEN, 128, cache line width in bits; multiple of 32, minimum 32
MEM_WORDS, 1024, backing store depth in 32-bit words; power of two
MEM_LATENCY, 5, wait cycles between request acceptance and first word read; 0 allowed

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  refill request valid
req_ready  out  1  responder can accept a request
req_addr  in  XLEN  byte address of the missing instruction
resp_valid  out  1  line data valid
resp_ready  in  1  requester accepts the line
resp_data  out  ICLLEN  assembled cache line
resp_addr  out  XLEN  line-aligned byte address of the returned line
wr_en  in  1  backing store word write enable
wr_addr  in  XLEN  byte address of the word to write
wr_data  in  32  word to write
busy  out  1  high in any state other than IDLE

Behaviour:
- Derived constants:
  - WORDS = ICLLEN/32.
  - OFF = log2(ICLLEN/8).
  - Word index = (addr >> 2) mod MEM_WORDS; addresses beyond the store wrap.
- Reset (async, active-high):
  - state = IDLE, all counters = 0, resp_valid = 0, resp_data = 0, resp_addr = 0, req_ready = 1, busy = 0.
  - Backing store contents are not reset.
  - Reset asserted mid-operation abandons the request; no response is ever produced for it.
- FSM states: IDLE, WAIT, BURST, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready at an edge, latch base = req_addr with the low OFF bits cleared.
  - Next state: WAIT if MEM_LATENCY > 0, else BURST.
- WAIT:
  - Counts exactly MEM_LATENCY cycles, then moves to BURST.
- BURST:
  - Cycle k (k = 0..WORDS-1) reads word index of (base + 4k).
  - The word is stored into resp_data[32k+31:32k] at the edge ending that cycle; word 0 is at the LSBs.
  - After k = WORDS-1, go to RESP.
- RESP:
  - resp_valid = 1, resp_addr = base.
  - resp_data and resp_addr stay stable while resp_valid && !resp_ready.
  - On resp_ready, go to IDLE.
  - A new request can be accepted no earlier than the cycle after the response handshake.
- Timing: if a request is accepted at the edge ending cycle T, resp_valid is first high in cycle T+1+MEM_LATENCY+WORDS. Defaults give T+10.
- req_ready = 0 in WAIT, BURST and RESP. req_valid in those states is ignored and is not queued.
- resp_valid is a registered output; it deasserts at the edge where the handshake occurs.
- Writes:
  - wr_en writes at the edge; accepted in every state.
  - A write to a word in an earlier cycle than its BURST read is visible to that read.
  - A write in the same cycle as the read of the same word is not visible; the read returns the old data.
- The backing store is an array without reset.

Test Plan:
- Preload words 0x00:0x11111111, 0x04:0x22222222, 0x08:0x33333333, 0x0C:0x44444444; request addr 0x00000008 at T -> resp_valid first high at T+10, resp_data = 0x44444444_33333333_22222222_11111111, resp_addr = 0x0, req_ready low T+1..T+10.
- Same request with resp_ready held low for 7 cycles -> resp_valid, resp_data and resp_addr stable for all 7 cycles; FSM in IDLE the cycle after resp_ready rises; a second req_valid during RESP is ignored.
- Request addr 0x00001010 with MEM_WORDS = 1024 -> returns words stored at byte addresses 0x10..0x1C (wrap-around).
- Assert rst two cycles into BURST -> resp_valid = 0 and req_ready = 1 immediately, with no response afterward. A new request after reset completes with the original preloaded data.
- During WAIT, write wr_addr = 0x04, wr_data = 0xDEADBEEF -> returned line bits [63:32] = 0xDEADBEEF. Writing word 0x0C in the cycle that reads word 0x0C -> bits [127:96] hold the old value.
- MEM_LATENCY = 0 build -> resp_valid first high at T+5.

Source files
------------

// File: rtl/icache_refill_responder.sv
// Memory-side responder for instruction-cache line refills.
// One request at a time: fixed wait of MEM_LATENCY cycles, then one word per
// cycle from an internal word-addressed store, then the assembled line is
// held on a valid/ready response channel. A word write port preloads images.
module icache_refill_responder #(
  parameter int XLEN        = 32,
  parameter int ICLLEN      = 128,
  parameter int MEM_WORDS   = 1024,
  parameter int MEM_LATENCY = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ICLLEN-1:0] resp_data,
  output logic [XLEN-1:0]   resp_addr,
  input  logic              wr_en,
  input  logic [XLEN-1:0]   wr_addr,
  input  logic [31:0]       wr_data,
  output logic              busy
);

  localparam int WORDS   = ICLLEN / 32;
  localparam int OFF     = $clog2(ICLLEN / 8);
  localparam int AW      = $clog2(MEM_WORDS);
  localparam int CNT_MAX = (MEM_LATENCY > WORDS) ? MEM_LATENCY : WORDS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Last count value of the wait phase and of the burst phase.
  localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'((MEM_LATENCY > 0) ? (MEM_LATENCY - 1) : 0);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORDS - 1);
  // Clears the byte offset within a line.
  localparam logic [XLEN-1:0]  LINE_MASK = {XLEN{1'b1}} << OFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     base_q, base_d;
  logic [ICLLEN-1:0]   data_q, data_d;
  logic                resp_valid_q, resp_valid_d;

  // Backing store: no reset, contents survive rst.
  logic [31:0]         mem_q [MEM_WORDS];

  logic [AW-1:0]       rd_idx_s;
  logic [AW-1:0]       wr_idx_s;
  logic [31:0]         rd_word_s;
  logic                wr_addr_unused_s;

  // Word index is the byte address divided by four, wrapped to the store depth;
  // the line base has zero low bits so adding the beat number just walks the line.
  assign rd_idx_s  = base_q[AW+1:2] + AW'(cnt_q);
  assign wr_idx_s  = wr_addr[AW+1:2];
  assign rd_word_s = mem_q[rd_idx_s];
  assign wr_addr_unused_s = ^{wr_addr[XLEN-1:AW+2], wr_addr[1:0]};

  // Store write port; a same-edge read still sees the previous word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx_s] <= wr_data;
    end
  end

  // Next-state, counter, line base and line assembly.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    data_d       = data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          base_d = req_addr & LINE_MASK;
          cnt_d  = {CNT_W{1'b0}};
          if (MEM_LATENCY > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_BURST;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_BURST;
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_BURST: begin
        data_d[{cnt_q, 5'd0} +: 32] = rd_word_s;
        if (cnt_q == WORD_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    resp_valid_d = (state_d == ST_RESP);
  end

  // State and output registers; reset abandons any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      base_q       <= {XLEN{1'b0}};
      data_q       <= {ICLLEN{1'b0}};
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      data_q       <= data_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = data_q;
  assign resp_addr  = base_q;
  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_icache_refill_responder.sv
// Directed bench for icache_refill_responder: default build (latency 5) plus
// a latency-0 build sharing the same clock and reset.
module tb_icache_refill_responder;

  logic         clk = 1'b0;
  logic         rst;

  logic         req_valid, req_ready, resp_valid, resp_ready, wr_en, busy;
  logic [31:0]  req_addr, resp_addr, wr_addr, wr_data;
  logic [127:0] resp_data;

  logic         req_valid_b, req_ready_b, resp_valid_b, resp_ready_b, wr_en_b, busy_b;
  logic [31:0]  req_addr_b, resp_addr_b, wr_addr_b, wr_data_b;
  logic [127:0] resp_data_b;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  icache_refill_responder #(.XLEN(32), .ICLLEN(128), .MEM_WORDS(1024), .MEM_LATENCY(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_addr(resp_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  icache_refill_responder #(.XLEN(32), .ICLLEN(128), .MEM_WORDS(1024), .MEM_LATENCY(0)) dut_lat0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
    .resp_data(resp_data_b), .resp_addr(resp_addr_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a);
    req_valid = 1'b1; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Returns the cycle offset (acceptance cycle = 0) of first resp_valid.
  task automatic wait_valid(output int lat, output bit rr_bad);
    lat = 1; rr_bad = 1'b0;
    while (resp_valid !== 1'b1 && lat < 40) begin
      if (req_ready !== 1'b0) rr_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (req_ready !== 1'b0) rr_bad = 1'b1;
  endtask

  task automatic handshake(input string tag);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_valid_drop"}, 128'(resp_valid), 128'd0);
    chk({tag, "_idle"},       128'(busy),       128'd0);
    chk({tag, "_ready"},      128'(req_ready),  128'd1);
  endtask

  localparam logic [127:0] LINE0 = 128'h44444444_33333333_22222222_11111111;

  initial begin
    int  lat;
    bit  rr_bad;
    bit  seen;

    rst = 1'b1;
    req_valid = 1'b0; req_addr = 32'd0; resp_ready = 1'b0;
    wr_en = 1'b0; wr_addr = 32'd0; wr_data = 32'd0;
    req_valid_b = 1'b0; req_addr_b = 32'd0; resp_ready_b = 1'b0;
    wr_en_b = 1'b0; wr_addr_b = 32'd0; wr_data_b = 32'd0;
    @(negedge clk); @(negedge clk);

    // Reset state
    chk("rst_valid", 128'(resp_valid), 128'd0);
    chk("rst_ready", 128'(req_ready),  128'd1);
    chk("rst_busy",  128'(busy),       128'd0);
    chk("rst_data",  resp_data,        128'd0);
    chk("rst_addr",  128'(resp_addr),  128'd0);
    rst = 1'b0;
    @(negedge clk);

    // Preload
    wr(32'h00, 32'h11111111);
    wr(32'h04, 32'h22222222);
    wr(32'h08, 32'h33333333);
    wr(32'h0C, 32'h44444444);
    wr(32'h10, 32'h55555555);
    wr(32'h14, 32'h66666666);
    wr(32'h18, 32'h77777777);
    wr(32'h1C, 32'h88888888);

    // Basic refill, latency and line assembly
    issue(32'h00000008);
    chk("t1_busy", 128'(busy), 128'd1);
    wait_valid(lat, rr_bad);
    chk("t1_latency",   128'(lat),       128'd10);
    chk("t1_ready_low", 128'(rr_bad),    128'd0);
    chk("t1_data",      resp_data,       LINE0);
    chk("t1_addr",      128'(resp_addr), 128'd0);
    handshake("t1");

    // Back-pressure for 7 cycles; request during RESP is ignored
    issue(32'h00000008);
    wait_valid(lat, rr_bad);
    chk("t2_latency", 128'(lat), 128'd10);
    for (int i = 0; i < 7; i++) begin
      chk("t2_hold_valid", 128'(resp_valid), 128'd1);
      chk("t2_hold_data",  resp_data,        LINE0);
      chk("t2_hold_addr",  128'(resp_addr),  128'd0);
      if (i == 2) begin
        req_valid = 1'b1; req_addr = 32'h00001010;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("t2_still_valid", 128'(resp_valid), 128'd1);
    handshake("t2");
    @(negedge clk); @(negedge clk);
    chk("t2_not_queued", 128'(busy), 128'd0);

    // Address wrap beyond the store depth
    issue(32'h00001010);
    wait_valid(lat, rr_bad);
    chk("t3_latency", 128'(lat), 128'd10);
    chk("t3_data", resp_data, 128'h88888888_77777777_66666666_55555555);
    chk("t3_addr", 128'(resp_addr), 128'h1010);
    handshake("t3");

    // Reset in the middle of the burst
    issue(32'h00000000);
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("t4_in_burst", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    chk("t4_rst_valid", 128'(resp_valid), 128'd0);
    chk("t4_rst_ready", 128'(req_ready),  128'd1);
    chk("t4_rst_busy",  128'(busy),       128'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    chk("t4_no_resp", 128'(seen), 128'd0);
    issue(32'h00000004);
    wait_valid(lat, rr_bad);
    chk("t4_latency", 128'(lat), 128'd10);
    chk("t4_data",    resp_data, LINE0);
    handshake("t4");

    // Writes during WAIT (visible) and same-cycle as read (not visible)
    req_valid = 1'b1; req_addr = 32'h00000000;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 40) begin
      if (lat == 2) begin
        wr_en = 1'b1; wr_addr = 32'h04; wr_data = 32'hDEADBEEF;
      end else if (lat == 9) begin
        wr_en = 1'b1; wr_addr = 32'h0C; wr_data = 32'hCAFEF00D;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    wr_en = 1'b0;
    chk("t5_latency", 128'(lat), 128'd10);
    chk("t5_wait_write", 128'(resp_data[63:32]),  128'hDEADBEEF);
    chk("t5_same_cycle", 128'(resp_data[127:96]), 128'h44444444);
    chk("t5_data", resp_data, 128'h44444444_33333333_DEADBEEF_11111111);
    handshake("t5");
    issue(32'h0000000C);
    wait_valid(lat, rr_bad);
    chk("t5_later_read", resp_data, 128'hCAFEF00D_33333333_DEADBEEF_11111111);
    handshake("t5b");

    // Zero-latency build
    for (int i = 0; i < 4; i++) begin
      wr_en_b = 1'b1; wr_addr_b = 32'(i * 4); wr_data_b = 32'hA0000000 + 32'(i);
      @(negedge clk);
    end
    wr_en_b = 1'b0;
    req_valid_b = 1'b1; req_addr_b = 32'h00000004;
    @(negedge clk);
    req_valid_b = 1'b0;
    lat = 1;
    while (resp_valid_b !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("t6_latency", 128'(lat), 128'd5);
    chk("t6_data", resp_data_b, 128'hA0000003_A0000002_A0000001_A0000000);
    chk("t6_addr", 128'(resp_addr_b), 128'd0);
    resp_ready_b = 1'b1;
    @(negedge clk);
    resp_ready_b = 1'b0;
    chk("t6_idle", 128'(busy_b), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
